// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port among the instruction and data requests of
// CPUS cores. Cores are served round-robin, and a core's data request beats its
// own instruction request. The block also holds the per-core LL/SC link
// registers, resolves SC success/failure, and kills links on conflicting stores.
module mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]        iwait,
    output logic [WORD_W-1:0]      iload,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0]        datomic,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [WORD_W-1:0]      dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramready
);

    localparam int IDX_W = $clog2(CPUS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic [2:0] {REQ_I, REQ_DR, REQ_DW, REQ_LL, REQ_SC} req_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    req_e               type_q, type_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  store_q, store_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [CPUS-1:0]    link_valid_q, link_valid_d;
    logic [WORD_W-1:0]  link_addr_q [CPUS];
    logic [WORD_W-1:0]  link_addr_d [CPUS];

    // Per-core views of the flattened address/data buses.
    logic [WORD_W-1:0]  iaddr_a  [CPUS];
    logic [WORD_W-1:0]  daddr_a  [CPUS];
    logic [WORD_W-1:0]  dstore_a [CPUS];

    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick;
    logic               found;
    req_e               pick_type;
    logic [WORD_W-1:0]  pick_addr;
    logic               pick_sc_ok;

    // Unpack the flattened per-core buses into arrays.
    always_comb begin
        for (int k = 0; k < CPUS; k++) begin
            iaddr_a[k]  = iaddr[k*WORD_W +: WORD_W];
            daddr_a[k]  = daddr[k*WORD_W +: WORD_W];
            dstore_a[k] = dstore[k*WORD_W +: WORD_W];
        end
    end

    // Round-robin search: the first requesting core after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= CPUS; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % CPUS);
            if (!found && (dREN[cand] || dWEN[cand] || iREN[cand])) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Classify the picked core's request; a write wins over a read.
    always_comb begin
        pick_type = REQ_I;
        pick_addr = iaddr_a[pick];
        if (dWEN[pick]) begin
            pick_type = datomic[pick] ? REQ_SC : REQ_DW;
            pick_addr = daddr_a[pick];
        end else if (dREN[pick]) begin
            pick_type = datomic[pick] ? REQ_LL : REQ_DR;
            pick_addr = daddr_a[pick];
        end
    end

    assign pick_sc_ok = link_valid_q[pick] && (link_addr_q[pick] == daddr_a[pick]);

    // Next-state logic for the grant FSM and the link registers.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        type_d       = type_q;
        addr_d       = addr_q;
        store_d      = store_q;
        data_d       = data_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d    = pick;
                    rr_ptr_d = pick;
                    type_d   = pick_type;
                    addr_d   = pick_addr;
                    store_d  = dstore_a[pick];
                    if ((pick_type == REQ_SC) && !pick_sc_ok) begin
                        // A failed SC never reaches the RAM.
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (ramready) begin
                    state_d = RESP;
                    case (type_q)
                        REQ_I, REQ_DR: data_d = ramload;
                        REQ_LL: begin
                            data_d              = ramload;
                            link_valid_d[gnt_q] = 1'b1;
                            link_addr_d[gnt_q]  = addr_q;
                        end
                        REQ_DW, REQ_SC: begin
                            // Any store kills other cores' links on this address.
                            for (int k = 0; k < CPUS; k++) begin
                                if ((IDX_W'(k) != gnt_q) && (link_addr_q[k] == addr_q))
                                    link_valid_d[k] = 1'b0;
                            end
                            // Only SC in ACCESS is a successful one.
                            if (type_q == REQ_SC) begin
                                link_valid_d[gnt_q] = 1'b0;
                                data_d              = WORD_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM drive during ACCESS and the one-cycle wait release during RESP.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == ACCESS) begin
            ramaddr  = addr_q;
            ramstore = store_q;
            ramREN   = (type_q == REQ_I) || (type_q == REQ_DR) || (type_q == REQ_LL);
            ramWEN   = (type_q == REQ_DW) || (type_q == REQ_SC);
        end else if (state_q == RESP) begin
            if (type_q == REQ_I) iwait[gnt_q] = 1'b0;
            else                 dwait[gnt_q] = 1'b0;
        end
    end

    assign iload = data_q;
    assign dload = data_q;

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of every other register.
        if (RST) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDX_W'(CPUS - 1);
            gnt_q        <= '0;
            type_q       <= REQ_I;
            addr_q       <= '0;
            store_q      <= '0;
            data_q       <= '0;
            link_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            store_q      <= store_d;
            data_q       <= data_d;
            link_valid_q <= link_valid_d;
        end
    end

    // Link address storage.
    always_ff @(posedge CLK) begin
        // NOTE: link addresses are not reset; they are qualified by
        // link_valid_q, which is.
        link_addr_q <= link_addr_d;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter with two cores. A small RAM
// responder raises ramready after ram_lat access cycles and returns ram_data.
// It also records the last RAM read/write and counts the cycles in which
// ramWEN is high.
module tb_mem_arbiter;

    localparam int CPUS = 2;
    localparam int W    = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic [CPUS-1:0]   iREN, dREN, dWEN, datomic;
    logic [CPUS*W-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]   iwait, dwait;
    logic [W-1:0]      iload, dload;
    logic              ramREN, ramWEN, ramready;
    logic [W-1:0]      ramaddr, ramstore, ramload;

    int                ram_lat = 1;
    logic [W-1:0]      ram_data = '0;
    int                acc_cnt = 0;
    int                wen_cycles = 0;
    logic [W-1:0]      last_rd_addr = '0;
    logic [W-1:0]      last_wr_addr = '0;
    logic [W-1:0]      last_wr_data = '0;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .datomic  (datomic),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
    );

    always #5 CLK = ~CLK;

    // RAM responder: ready on the ram_lat-th cycle of an access.
    assign ramready = (ramREN || ramWEN) && (acc_cnt == ram_lat - 1);
    assign ramload  = ram_data;

    // Track access length and record completed RAM transfers.
    always @(posedge CLK) begin
        acc_cnt <= (ramREN || ramWEN) ? acc_cnt + 1 : 0;
        if (ramREN && ramready) last_rd_addr <= ramaddr;
        if (ramWEN && ramready) begin
            last_wr_addr <= ramaddr;
            last_wr_data <= ramstore;
        end
        if (ramWEN) wen_cycles <= wen_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance until some wait bit is low, with a bounded cycle budget.
    task automatic wait_resp(input string tag, output int cyc);
        cyc = 0;
        while ((&iwait) && (&dwait) && (cyc < 50)) begin
            tick();
            cyc++;
        end
        check({tag, " timeout"}, 64'(cyc < 50), 64'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int cyc;
        int wen0;

        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; datomic = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        tick();
        tick();

        // Reset state
        check("rst iwait", 64'(iwait), 64'h3);
        check("rst dwait", 64'(dwait), 64'h3);
        check("rst ramREN", 64'(ramREN), 64'h0);
        check("rst ramWEN", 64'(ramWEN), 64'h0);
        check("rst ramaddr", 64'(ramaddr), 64'h0);
        check("rst ramstore", 64'(ramstore), 64'h0);
        check("rst iload", 64'(iload), 64'h0);
        check("rst dload", 64'(dload), 64'h0);
        RST = 1'b0;

        // Instruction fetch, 2-cycle RAM: IDLE + 2xACCESS + RESP
        iREN[0] = 1'b1; iaddr[31:0] = 32'h40; ram_lat = 2; ram_data = 32'h8C010004;
        tick();
        check("t1 acc1 ramREN", 64'(ramREN), 64'h1);
        check("t1 acc1 ramaddr", 64'(ramaddr), 64'h40);
        check("t1 acc1 iwait", 64'(iwait), 64'h3);
        tick();
        check("t1 acc2 ramREN", 64'(ramREN), 64'h1);
        tick();
        check("t1 resp ramREN", 64'(ramREN), 64'h0);
        check("t1 resp iwait", 64'(iwait), 64'h2);
        check("t1 resp dwait", 64'(dwait), 64'h3);
        check("t1 resp iload", 64'(iload), 64'h8C010004);
        iREN[0] = 1'b0;
        tick();
        check("t1 idle iwait", 64'(iwait), 64'h3);

        // Round-robin from reset: core0, core1, core0
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ram_lat = 1; ram_data = 32'h11110000;
        dREN = 2'b11; daddr = {32'h20, 32'h10};
        wait_resp("t2 g1", cyc);
        check("t2 g1 dwait", 64'(dwait), 64'h2);
        check("t2 g1 latency", 64'(cyc), 64'd2);
        check("t2 g1 addr", 64'(last_rd_addr), 64'h10);
        check("t2 g1 dload", 64'(dload), 64'h11110000);
        tick();
        wait_resp("t2 g2", cyc);
        check("t2 g2 dwait", 64'(dwait), 64'h1);
        check("t2 g2 addr", 64'(last_rd_addr), 64'h20);
        tick();
        wait_resp("t2 g3", cyc);
        check("t2 g3 dwait", 64'(dwait), 64'h2);
        dREN = '0;
        tick();

        // Same core: data write beats instruction read
        iREN[0] = 1'b1; iaddr[31:0] = 32'h44;
        dWEN[0] = 1'b1; daddr[31:0] = 32'h30; dstore[31:0] = 32'h1234;
        ram_data = 32'h5555;
        wait_resp("t3 wr", cyc);
        check("t3 wr dwait", 64'(dwait), 64'h2);
        check("t3 wr iwait", 64'(iwait), 64'h3);
        check("t3 wr addr", 64'(last_wr_addr), 64'h30);
        check("t3 wr data", 64'(last_wr_data), 64'h1234);
        dWEN[0] = 1'b0;
        tick();
        wait_resp("t3 rd", cyc);
        check("t3 rd iwait", 64'(iwait), 64'h2);
        check("t3 rd addr", 64'(last_rd_addr), 64'h44);
        check("t3 rd iload", 64'(iload), 64'h5555);
        iREN[0] = 1'b0;
        tick();

        // LL then SC succeeds, second SC fails
        datomic[0] = 1'b1; dREN[0] = 1'b1; daddr[31:0] = 32'h100; ram_data = 32'hCAFE;
        wait_resp("t4 ll", cyc);
        check("t4 ll dwait", 64'(dwait), 64'h2);
        check("t4 ll dload", 64'(dload), 64'hCAFE);
        dREN[0] = 1'b0;
        tick();
        dWEN[0] = 1'b1; dstore[31:0] = 32'hBEEF;
        wait_resp("t4 sc1", cyc);
        check("t4 sc1 latency", 64'(cyc), 64'd2);
        check("t4 sc1 dload", 64'(dload), 64'h1);
        check("t4 sc1 wr addr", 64'(last_wr_addr), 64'h100);
        check("t4 sc1 wr data", 64'(last_wr_data), 64'hBEEF);
        dWEN[0] = 1'b0;
        tick();
        wen0 = wen_cycles;
        dWEN[0] = 1'b1;
        wait_resp("t4 sc2", cyc);
        check("t4 sc2 latency", 64'(cyc), 64'd1);
        check("t4 sc2 dwait", 64'(dwait), 64'h2);
        check("t4 sc2 dload", 64'(dload), 64'h0);
        dWEN[0] = 1'b0;
        tick();
        check("t4 sc2 no ramWEN", 64'(wen_cycles), 64'(wen0));

        // Core1 store to the linked address breaks core0's link
        dREN[0] = 1'b1; daddr[31:0] = 32'h200;
        wait_resp("t5 ll", cyc);
        dREN[0] = 1'b0;
        tick();
        dWEN[1] = 1'b1; daddr[63:32] = 32'h200; dstore[63:32] = 32'h77;
        wait_resp("t5 sw", cyc);
        check("t5 sw dwait", 64'(dwait), 64'h1);
        dWEN[1] = 1'b0;
        tick();
        wen0 = wen_cycles;
        dWEN[0] = 1'b1; dstore[31:0] = 32'h99;
        wait_resp("t5 sc", cyc);
        check("t5 sc latency", 64'(cyc), 64'd1);
        check("t5 sc dload", 64'(dload), 64'h0);
        dWEN[0] = 1'b0;
        tick();
        check("t5 sc no ramWEN", 64'(wen_cycles), 64'(wen0));

        // Store to a different address leaves the link intact
        dREN[0] = 1'b1;
        wait_resp("t5b ll", cyc);
        dREN[0] = 1'b0;
        tick();
        dWEN[1] = 1'b1; daddr[63:32] = 32'h204;
        wait_resp("t5b sw", cyc);
        dWEN[1] = 1'b0;
        tick();
        dWEN[0] = 1'b1;
        wait_resp("t5b sc", cyc);
        check("t5b sc dload", 64'(dload), 64'h1);
        check("t5b sc wr data", 64'(last_wr_data), 64'h99);
        dWEN[0] = 1'b0;
        tick();

        // Reset during ACCESS abandons the access and clears links
        dREN[0] = 1'b1; daddr[31:0] = 32'h600;
        wait_resp("t6 ll", cyc);
        dREN[0] = 1'b0;
        tick();
        dREN[1] = 1'b1; daddr[63:32] = 32'h500; ram_lat = 5; ram_data = 32'hABCD;
        tick();
        check("t6 acc ramREN", 64'(ramREN), 64'h1);
        check("t6 acc ramaddr", 64'(ramaddr), 64'h500);
        RST = 1'b1;
        tick();
        check("t6 rst iwait", 64'(iwait), 64'h3);
        check("t6 rst dwait", 64'(dwait), 64'h3);
        check("t6 rst ramREN", 64'(ramREN), 64'h0);
        check("t6 rst ramWEN", 64'(ramWEN), 64'h0);
        check("t6 rst ramaddr", 64'(ramaddr), 64'h0);
        check("t6 rst dload", 64'(dload), 64'h0);
        RST = 1'b0;
        ram_lat = 2;
        wait_resp("t6 rearb", cyc);
        check("t6 rearb latency", 64'(cyc), 64'd3);
        check("t6 rearb dwait", 64'(dwait), 64'h1);
        check("t6 rearb dload", 64'(dload), 64'hABCD);
        dREN[1] = 1'b0;
        tick();
        dWEN[0] = 1'b1;
        wait_resp("t6 sc", cyc);
        check("t6 sc latency", 64'(cyc), 64'd1);
        check("t6 sc dload", 64'(dload), 64'h0);
        dWEN[0] = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
